// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Pops bytes from a registered-output FIFO and serialises each as
//            a UART frame (start bit, WIDTH data bits LSB first, STOP_BITS
//            stop bits) on the tx line.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           system clock, rising edge active
//   rst           asynchronous active-high reset
//   enable        permits new frames; looked at only between frames
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    one-cycle pop strobe to the FIFO
//   fifo_rd_data  FIFO read data, valid on the edge after the strobe cycle
//   tx            UART serial output, idle high
//   busy          high from the pop strobe to the end of the last stop bit
//   byte_done     one-cycle pulse once the last stop bit has completed
// ============================================================================
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int WIDTH        = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             tx,
    output logic             busy,
    output logic             byte_done
);

    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_BIT_W  = $clog2(WIDTH + 1);

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
    localparam logic [c_BIT_W-1:0]  c_BIT_ONE   = c_BIT_W'(1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(WIDTH - 1);
    localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t               r_state_q,     w_state_d;
    logic [c_BAUD_W-1:0]  r_baud_q,      w_baud_d;
    logic [c_BIT_W-1:0]   r_bit_q,       w_bit_d;
    logic [WIDTH-1:0]     r_shift_q,     w_shift_d;
    logic                 r_tx_q,        w_tx_d;
    logic                 r_rd_en_q,     w_rd_en_d;
    logic                 r_busy_q,      w_busy_d;
    logic                 r_byte_done_q, w_byte_done_d;

    logic                 w_pop;
    logic                 w_baud_wrap;
    logic [WIDTH-1:0]     w_shift_shr;

    assign w_pop       = enable & ~fifo_empty;
    assign w_baud_wrap = (r_baud_q == c_BAUD_LAST);
    assign w_shift_shr = {1'b0, r_shift_q[WIDTH-1:1]};

    // Every output is a flop, so the pop decision is taken one cycle before
    // the strobe is visible: in IDLE for a fresh start, or in the last stop
    // cycle for back-to-back traffic. The strobe cycle itself is spent in
    // IDLE, which keeps the idle-high gap between frames at two cycles.
    always_comb begin
        w_state_d     = r_state_q;
        w_baud_d      = r_baud_q;
        w_bit_d       = r_bit_q;
        w_shift_d     = r_shift_q;
        w_tx_d        = r_tx_q;
        w_rd_en_d     = 1'b0;
        w_busy_d      = r_busy_q;
        w_byte_done_d = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                w_tx_d = 1'b1;
                if (r_rd_en_q) begin
                    w_state_d = S_FETCH;
                end else if (w_pop) begin
                    w_rd_en_d = 1'b1;
                    w_busy_d  = 1'b1;
                end else begin
                    w_busy_d  = 1'b0;
                end
            end

            S_FETCH: begin
                // FIFO read data settles one edge after the strobe was seen.
                w_shift_d = fifo_rd_data;
                w_tx_d    = 1'b0;
                w_baud_d  = '0;
                w_state_d = S_START;
            end

            S_START: begin
                if (w_baud_wrap) begin
                    w_baud_d  = '0;
                    w_bit_d   = '0;
                    w_tx_d    = r_shift_q[0];
                    w_state_d = S_DATA;
                end else begin
                    w_baud_d  = r_baud_q + c_BAUD_ONE;
                end
            end

            S_DATA: begin
                if (w_baud_wrap) begin
                    w_baud_d  = '0;
                    w_shift_d = w_shift_shr;
                    if (r_bit_q == c_BIT_LAST) begin
                        w_bit_d   = '0;
                        w_tx_d    = 1'b1;
                        w_state_d = S_STOP;
                    end else begin
                        w_bit_d   = r_bit_q + c_BIT_ONE;
                        w_tx_d    = w_shift_shr[0];
                    end
                end else begin
                    w_baud_d  = r_baud_q + c_BAUD_ONE;
                end
            end

            S_STOP: begin
                // The bit index is reused to count stop bits.
                if (w_baud_wrap) begin
                    w_baud_d = '0;
                    if (r_bit_q == c_STOP_LAST) begin
                        w_bit_d       = '0;
                        w_byte_done_d = 1'b1;
                        w_state_d     = S_IDLE;
                        w_rd_en_d     = w_pop;
                        w_busy_d      = w_pop;
                    end else begin
                        w_bit_d  = r_bit_q + c_BIT_ONE;
                    end
                end else begin
                    w_baud_d = r_baud_q + c_BAUD_ONE;
                end
            end

            default: begin
                w_state_d = S_IDLE;
                w_tx_d    = 1'b1;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_baud_q      <= '0;
            r_bit_q       <= '0;
            r_shift_q     <= '0;
            r_tx_q        <= 1'b1;
            r_rd_en_q     <= 1'b0;
            r_busy_q      <= 1'b0;
            r_byte_done_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_baud_q      <= w_baud_d;
            r_bit_q       <= w_bit_d;
            r_shift_q     <= w_shift_d;
            r_tx_q        <= w_tx_d;
            r_rd_en_q     <= w_rd_en_d;
            r_busy_q      <= w_busy_d;
            r_byte_done_q <= w_byte_done_d;
        end
    end

    assign tx         = r_tx_q;
    assign fifo_rd_en = r_rd_en_q;
    assign busy       = r_busy_q;
    assign byte_done  = r_byte_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Self-checking bench for fifo_uart_tx. Two instances (4 clk/bit
//            with 1 stop bit, 3 clk/bit with 2 stop bits) each fed by a small
//            FIFO model. Line activity is logged per cycle and frames are
//            decoded from the log against the queue of bytes pushed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int W     = 8;
    localparam int CPB_A = 4;
    localparam int SB_A  = 1;
    localparam int CPB_B = 3;
    localparam int SB_B  = 2;
    localparam int LOG   = 4096;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic enable = 1'b0;

    logic       empty_a, rd_a, tx_a, busy_a, bd_a;
    logic       empty_b, rd_b, tx_b, busy_b, bd_b;
    logic [7:0] rdata_a = 8'h00;
    logic [7:0] rdata_b = 8'h00;

    // FIFO models: pushes from the stimulus process, pops from the clock.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] wp_a = 8'd0, rp_a = 8'd0, wp_b = 8'd0, rp_b = 8'd0;
    int         pop_err_a = 0, pop_err_b = 0;

    assign empty_a = (wp_a == rp_a);
    assign empty_b = (wp_b == rp_b);

    fifo_uart_tx #(.CLKS_PER_BIT(CPB_A), .WIDTH(W), .STOP_BITS(SB_A)) u_dut_a (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty_a),
        .fifo_rd_en(rd_a), .fifo_rd_data(rdata_a), .tx(tx_a),
        .busy(busy_a), .byte_done(bd_a)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB_B), .WIDTH(W), .STOP_BITS(SB_B)) u_dut_b (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty_b),
        .fifo_rd_en(rd_b), .fifo_rd_data(rdata_b), .tx(tx_b),
        .busy(busy_b), .byte_done(bd_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_a) begin
            if (empty_a) pop_err_a <= pop_err_a + 1;
            rdata_a <= mem_a[rp_a];
            rp_a    <= rp_a + 8'd1;
        end
        if (rd_b) begin
            if (empty_b) pop_err_b <= pop_err_b + 1;
            rdata_b <= mem_b[rp_b];
            rp_b    <= rp_b + 8'd1;
        end
    end

    // Cycle index: cycle c runs from posedge c to posedge c+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit tx_log   [2][LOG];
    bit rd_log   [2][LOG];
    bit bd_log   [2][LOG];
    bit busy_log [2][LOG];

    always @(negedge clk) begin
        if (cyc < LOG) begin
            tx_log[0][cyc]   <= tx_a;
            rd_log[0][cyc]   <= rd_a;
            bd_log[0][cyc]   <= bd_a;
            busy_log[0][cyc] <= busy_a;
            tx_log[1][cyc]   <= tx_b;
            rd_log[1][cyc]   <= rd_b;
            bd_log[1][cyc]   <= bd_b;
            busy_log[1][cyc] <= busy_b;
        end
    end

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] expq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] b);
        mem_a[wp_a] = b;
        wp_a = wp_a + 8'd1;
    endtask

    task automatic push_b(input logic [7:0] b);
        mem_b[wp_b] = b;
        wp_b = wp_b + 8'd1;
    endtask

    // sel: 0 pops, 1 byte_done pulses, 2 busy cycles, 3 tx-low cycles
    function automatic int count_log(input int sel, input int dut, input int a, input int b);
        int n = 0;
        for (int c = a; c < b; c++) begin
            case (sel)
                0:       n += int'(rd_log[dut][c]);
                1:       n += int'(bd_log[dut][c]);
                2:       n += int'(busy_log[dut][c]);
                default: n += int'(!tx_log[dut][c]);
            endcase
        end
        return n;
    endfunction

    function automatic int find_pop(input int dut, input int from);
        for (int c = from; c < LOG; c++) begin
            if (rd_log[dut][c]) return c;
        end
        return -1;
    endfunction

    task automatic wait_pop(input int dut, input int limit, output int p);
        p = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((dut == 0) ? rd_a : rd_b) begin
                p = cyc;
                break;
            end
        end
        chk("wait_pop_timeout", (p >= 0) ? 1 : 0, 1);
    endtask

    // Decodes every frame popped inside [a,b) and compares it with exp.
    task automatic verify(input string tag, input int dut, input int a, input int b,
                          input logic [7:0] exp[$]);
        int pops[$];
        int cpb  = (dut == 0) ? CPB_A : CPB_B;
        int sb   = (dut == 0) ? SB_A  : SB_B;
        int flen = (1 + W + sb) * cpb;
        for (int c = a; c < b; c++) begin
            if (rd_log[dut][c]) pops.push_back(c);
        end
        chk($sformatf("%s.pop_count", tag), pops.size(), exp.size());
        chk($sformatf("%s.done_count", tag), count_log(1, dut, a, b), exp.size());
        for (int k = 0; k < pops.size() && k < exp.size(); k++) begin
            int         p;
            int         base;
            logic [7:0] got;
            bit         st_ok, stable, sp_ok, busy_ok;
            p       = pops[k];
            base    = p + 2;
            got     = 8'h00;
            st_ok   = 1'b1;
            stable  = 1'b1;
            sp_ok   = 1'b1;
            busy_ok = 1'b1;
            for (int j = 0; j < cpb; j++) if (tx_log[dut][base + j]) st_ok = 1'b0;
            for (int i = 0; i < W; i++) begin
                got[i] = tx_log[dut][base + cpb * (1 + i)];
                for (int j = 0; j < cpb; j++)
                    if (tx_log[dut][base + cpb * (1 + i) + j] != got[i]) stable = 1'b0;
            end
            for (int j = 0; j < cpb * sb; j++)
                if (!tx_log[dut][base + cpb * (1 + W) + j]) sp_ok = 1'b0;
            for (int j = 0; j < flen + 2; j++)
                if (!busy_log[dut][p + j]) busy_ok = 1'b0;
            chk($sformatf("%s[%0d].idle_before_start", tag, k),
                {31'd0, tx_log[dut][p] & tx_log[dut][p + 1]}, 1);
            chk($sformatf("%s[%0d].single_strobe", tag, k), {31'd0, rd_log[dut][p + 1]}, 0);
            chk($sformatf("%s[%0d].start_bit", tag, k), {31'd0, st_ok}, 1);
            chk($sformatf("%s[%0d].data", tag, k), {24'd0, got}, {24'd0, exp[k]});
            chk($sformatf("%s[%0d].bit_stable", tag, k), {31'd0, stable}, 1);
            chk($sformatf("%s[%0d].stop_bits", tag, k), {31'd0, sp_ok}, 1);
            chk($sformatf("%s[%0d].done_at_end", tag, k), {31'd0, bd_log[dut][base + flen]}, 1);
            chk($sformatf("%s[%0d].done_not_early", tag, k), {31'd0, bd_log[dut][base + flen - 1]}, 0);
            chk($sformatf("%s[%0d].busy_span", tag, k), {31'd0, busy_ok}, 1);
            if (!rd_log[dut][base + flen])
                chk($sformatf("%s[%0d].busy_falls", tag, k), {31'd0, busy_log[dut][base + flen]}, 0);
        end
    endtask

    initial begin
        int         s, r, p, p1, p2, p3;
        bit         found;
        logic [7:0] b1, b2;

        // Reset and idle behaviour
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.tx", {31'd0, tx_a}, 1);
        chk("rst.busy", {31'd0, busy_a}, 0);
        chk("rst.rd_en", {31'd0, rd_a}, 0);
        chk("rst.byte_done", {31'd0, bd_a}, 0);
        chk("rst.tx_b", {31'd0, tx_b}, 1);
        rst    = 1'b0;
        enable = 1'b1;
        s      = cyc;
        repeat (100) @(negedge clk);
        chk("idle.no_pop", count_log(0, 0, s, cyc), 0);
        chk("idle.no_busy", count_log(2, 0, s, cyc), 0);
        chk("idle.tx_high", count_log(3, 0, s, cyc), 0);

        // Single byte 0xA5
        expq = {};
        s    = cyc;
        push_a(8'hA5);
        expq.push_back(8'hA5);
        wait_pop(0, 5, p);
        chk("single.pop_latency", p, s + 1);
        repeat (50) @(negedge clk);
        verify("single", 0, s, cyc, expq);

        // Back-to-back: three preloaded bytes
        enable = 1'b0;
        expq   = {};
        push_a(8'h00); expq.push_back(8'h00);
        push_a(8'hFF); expq.push_back(8'hFF);
        push_a(8'h3C); expq.push_back(8'h3C);
        @(negedge clk);
        s      = cyc;
        enable = 1'b1;
        wait_pop(0, 5, p1);
        chk("b2b.pop_latency", p1, s + 1);
        repeat (135) @(negedge clk);
        verify("b2b", 0, s, cyc, expq);
        p2 = find_pop(0, p1 + 1);
        p3 = find_pop(0, p2 + 1);
        chk("b2b.spacing12", p2 - p1, (1 + W + SB_A) * CPB_A + 2);
        chk("b2b.spacing23", p3 - p2, (1 + W + SB_A) * CPB_A + 2);
        chk("b2b.fifo_empty", {31'd0, empty_a}, 1);

        // Random bytes pushed at random intervals
        expq = {};
        s    = cyc;
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            b1 = 8'($urandom_range(0, 255));
            push_a(b1);
            expq.push_back(b1);
        end
        found = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (empty_a && !busy_a && !rd_a) begin
                found = 1'b1;
                break;
            end
        end
        chk("rand.drained", {31'd0, found}, 1);
        repeat (3) @(negedge clk);
        verify("rand", 0, s, cyc, expq);

        // Enable dropped during data bit 3 of the first of two bytes
        expq = {};
        s    = cyc;
        b1   = 8'($urandom_range(0, 255));
        b2   = 8'($urandom_range(0, 255));
        push_a(b1); expq.push_back(b1);
        push_a(b2); expq.push_back(b2);
        wait_pop(0, 5, p1);
        while (cyc < p1 + 2 + CPB_A * 4 + 1) @(negedge clk);
        enable = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bd_a) begin
                found = 1'b1;
                break;
            end
        end
        chk("gate.first_done", {31'd0, found}, 1);
        repeat (20) @(negedge clk);
        chk("gate.no_second_pop", count_log(0, 0, p1 + 1, cyc), 0);
        chk("gate.byte_pending", {31'd0, empty_a}, 0);
        r      = cyc;
        enable = 1'b1;
        wait_pop(0, 5, p2);
        chk("gate.resume_latency", p2, r + 1);
        repeat (50) @(negedge clk);
        verify("gate", 0, s, cyc, expq);

        // Reset during data bit 5; the popped byte is lost
        b1 = 8'($urandom_range(0, 255)) & 8'hDF;
        b2 = 8'($urandom_range(0, 255));
        push_a(b1);
        push_a(b2);
        wait_pop(0, 5, p1);
        while (cyc < p1 + 2 + CPB_A * 6 + 1) @(negedge clk);
        chk("rstmid.bit5_low", {31'd0, tx_a}, 0);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.tx_high", {31'd0, tx_a}, 1);
        chk("rstmid.busy_low", {31'd0, busy_a}, 0);
        chk("rstmid.rd_en_low", {31'd0, rd_a}, 0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        s    = cyc;
        expq = {};
        expq.push_back(b2);
        wait_pop(0, 5, p2);
        chk("rstmid.pop_latency", p2, s + 1);
        repeat (50) @(negedge clk);
        verify("rstmid", 0, s, cyc, expq);
        chk("rstmid.fifo_empty", {31'd0, empty_a}, 1);

        // Two stop bits, 3 clk per bit
        expq = {};
        s    = cyc;
        push_b(8'h81); expq.push_back(8'h81);
        b1 = 8'($urandom_range(0, 255));
        push_b(b1); expq.push_back(b1);
        wait_pop(1, 5, p1);
        chk("sb2.pop_latency", p1, s + 1);
        repeat (80) @(negedge clk);
        verify("sb2", 1, s, cyc, expq);
        p2 = find_pop(1, p1 + 1);
        chk("sb2.spacing", p2 - p1, (1 + W + SB_B) * CPB_B + 2);
        chk("sb2.stop_low_cycles", count_log(3, 1, p1 + 2 + CPB_B * (1 + W),
                                             p1 + 2 + CPB_B * (1 + W + SB_B)), 0);

        chk("never_pop_when_empty", pop_err_a + pop_err_b, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
